cu_decode_seq: RTL and testbench
================================

# cu_decode_seq

Control-unit sequencer that owns the handshake between instruction fetch, the instruction decode unit (IDU) and the execute stage. It accepts one instruction from fetch, launches the IDU with a single-cycle start pulse, and waits for decode completion with a timeout. It holds the issue while a load-use hazard exists, tracked in a 32-entry pending-load scoreboard, then hands the decoded instruction to execute over a valid/ready handshake. It sits in the CU between the fetch interface and the decode wrapper and drives the IDU's start, stall and instruction inputs.

## Interface
- TIMEOUT_CYCLES, 15: maximum number of WAIT_IDU cycles before the timeout error fires; legal range 1..255.
- soc_clk  in  1  clock; all logic is on the rising edge.
- CU_reset_n  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  fetch presents an instruction.
- fetch_instr  in  32  instruction word from fetch.
- fetch_ready  out  1  sequencer accepts an instruction.
- decode_start  out  1  one-cycle start pulse to the IDU.
- IDU_instr  out  32  latched instruction driven to the IDU.
- IDU_stall  out  1  high while a hazard holds the issue.
- IDU_ready  in  1  decode complete; sideband inputs are valid this cycle.
- IDU_invalid  in  1  decoded instruction is illegal.
- IDU_is_load  in  1  decoded instruction is a load.
- IDU_rd, IDU_rs1, IDU_rs2  in  5 each  decoded register indices.
- ex_valid  out  1  decoded instruction offered to execute.
- ex_ready  in  1  execute accepts.
- wb_valid  in  1  a load writeback completes.
- wb_rd  in  5  destination register of that writeback.
- flush  in  1  synchronous pipeline flush (taken branch or jump).
- err_clear  in  1  clears the error state.
- timeout_err, invalid_err  out  1 each  sticky error flags.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

## Operation
- Reset values: all outputs 0 and IDU_instr = 0, except fetch_ready, which is 1 because the state is IDLE. The scoreboard resets to all clear.
- IDLE: fetch_ready = 1. When fetch_valid is high, latch fetch_instr into IDU_instr and go to DECODE.
- DECODE: decode_start = 1 for exactly one cycle; the timeout counter clears. Next state is WAIT_IDU.
- WAIT_IDU: the counter increments every cycle.
  - If IDU_ready and IDU_invalid: go to ERROR and set invalid_err.
  - Else if IDU_ready: register rd, rs1, rs2 and is_load, then go to HAZARD.
  - Else if the counter reaches TIMEOUT_CYCLES: go to ERROR and set timeout_err.
  - IDU_ready takes priority over timeout in the same cycle.
- HAZARD: a hazard exists when pending[rs1] or pending[rs2] is set. pending[0] is hardwired to 0.
  - While a hazard exists: IDU_stall = 1, stall_cnt increments and saturates at 0xFFFF.
  - Otherwise go to ISSUE.
- ISSUE: ex_valid = 1, combinationally masked by flush, and held until ex_ready.
  - On the handshake, if is_load is set and rd != 0, set pending[rd]. Then go to IDLE.
- ERROR: both error flags are sticky. err_clear returns the FSM to IDLE and clears both flags. flush is ignored in this state.
- flush in DECODE, WAIT_IDU, HAZARD or ISSUE: go to IDLE next cycle, drop the instruction, no handshake, scoreboard unchanged.
- flush in IDLE blocks acceptance that cycle.
- Scoreboard clear: wb_valid clears pending[wb_rd]. If a set and a clear target the same index in the same cycle, the set wins.

## Timing
- The pending bits are registered. A wb_valid clear is visible to HAZARD one cycle later, so ex_valid rises 2 cycles after the clearing wb_valid.
- With IDU_ready asserted N cycles after decode_start, no hazard and ex_ready tied high:
  - accept at cycle 0, decode_start at cycle 1, HAZARD at cycle N+2, ex_valid at cycle N+3, fetch_ready at cycle N+4.
- Throughput is at most 1 instruction per N+4 cycles.
- decode_start never rises while the FSM is outside DECODE.
- Assertion of CU_reset_n in any state gives immediate reset values. No partial handshake survives reset.

## Structure
- cu_pkg holds:
  - the state enum cu_dseq_state_t: IDLE, DECODE, WAIT_IDU, HAZARD, ISSUE, ERROR;
  - the constants REG_IDX_W = 5 and STALL_CNT_W = 16.
- One sub-module, cu_scoreboard: 32-bit pending vector, set port, clear port, two combinational read ports, set-over-clear priority.
- The top level holds the FSM, the instruction latch, the timeout counter and the stall counter.

## Test plan
- Basic: fetch_instr = 0x00500093, IDU_ready 2 cycles after decode_start, ex_ready = 1 → one decode_start pulse, ex_valid for exactly 1 cycle at cycle 5, fetch_ready high at cycle 6.
- Load-use: issue a load with rd = 5, then an instruction with rs1 = 5 → IDU_stall stays high until wb_valid with wb_rd = 5, ex_valid 2 cycles after that, stall_cnt equals the number of stalled cycles.
- Timeout: IDU_ready never asserted → timeout_err after 15 WAIT_IDU cycles, fetch_ready low; err_clear → IDLE with fetch_ready = 1.
- Invalid plus priority: IDU_ready and IDU_invalid asserted in the same cycle the counter hits 15 → invalid_err = 1, timeout_err = 0.
- Flush in ISSUE with ex_ready = 1 on a load with rd = 7 → ex_valid = 0 that cycle, pending[7] stays clear, FSM returns to IDLE.
- Simultaneous events and reset:
  - wb_valid clear of rd = 3 in the same cycle a load to rd = 3 issues → pending[3] = 1.
  - Reset pulsed during WAIT_IDU → every output at its reset value immediately, next fetch accepted normally.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and constants for the control-unit decode sequencer.
package cu_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int STALL_CNT_W = 16;
  localparam int INSTR_W     = 32;
  localparam int TMO_CNT_W   = 8;
  localparam int NUM_REGS    = 1 << REG_IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT_IDU,
    HAZARD,
    ISSUE,
    ERROR
  } cu_dseq_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cu_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, x0 never pending.
module cu_scoreboard
  import cu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rd_idx_a,
  input  logic [REG_IDX_W-1:0] rd_idx_b,
  output logic                 rd_a,
  output logic                 rd_b
);

  logic [NUM_REGS-1:0] pending_reg;
  logic [NUM_REGS-1:0] pending_next;
  logic [NUM_REGS-1:0] set_dec;
  logic [NUM_REGS-1:0] clr_dec;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
    assign set_dec[gi] = set_en && (set_idx == REG_IDX_W'(gi));
    assign clr_dec[gi] = clr_en && (clr_idx == REG_IDX_W'(gi));
  end

  // Clear first, then set, so a same-index set wins; bit 0 is forced low.
  assign pending_next = ((pending_reg & ~clr_dec) | set_dec) & ~NUM_REGS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign rd_a = pending_reg[rd_idx_a];
  assign rd_b = pending_reg[rd_idx_b];

endmodule

// File: rtl/cu_decode_seq.sv
// Fetch -> IDU -> execute sequencer with decode timeout and load-use hazard hold.
module cu_decode_seq
  import cu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   soc_clk,
  input  logic                   CU_reset_n,
  input  logic                   fetch_valid,
  input  logic [INSTR_W-1:0]     fetch_instr,
  output logic                   fetch_ready,
  output logic                   decode_start,
  output logic [INSTR_W-1:0]     IDU_instr,
  output logic                   IDU_stall,
  input  logic                   IDU_ready,
  input  logic                   IDU_invalid,
  input  logic                   IDU_is_load,
  input  logic [REG_IDX_W-1:0]   IDU_rd,
  input  logic [REG_IDX_W-1:0]   IDU_rs1,
  input  logic [REG_IDX_W-1:0]   IDU_rs2,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  input  logic                   wb_valid,
  input  logic [REG_IDX_W-1:0]   wb_rd,
  input  logic                   flush,
  input  logic                   err_clear,
  output logic                   timeout_err,
  output logic                   invalid_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  cu_dseq_state_t state_reg;
  cu_dseq_state_t state_next;

  logic [INSTR_W-1:0]     instr_reg;
  logic [REG_IDX_W-1:0]   rd_reg;
  logic [REG_IDX_W-1:0]   rs1_reg;
  logic [REG_IDX_W-1:0]   rs2_reg;
  logic                   is_load_reg;
  logic [TMO_CNT_W-1:0]   tmo_cnt_reg;
  logic [TMO_CNT_W-1:0]   tmo_cnt_inc;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;
  logic                   timeout_err_reg;
  logic                   invalid_err_reg;

  logic accept;
  logic capture;
  logic set_tmo;
  logic set_inv;
  logic issue_fire;
  logic stall_inc;
  logic hazard;
  logic pend_rs1;
  logic pend_rs2;
  logic tmo_hit;
  logic sb_set;

  assign tmo_cnt_inc = tmo_cnt_reg + TMO_CNT_W'(1);
  assign tmo_hit     = (tmo_cnt_inc == TMO_CNT_W'(TIMEOUT_CYCLES));
  assign hazard      = pend_rs1 | pend_rs2;
  assign sb_set      = issue_fire && is_load_reg && (rd_reg != '0);

  cu_scoreboard u_scoreboard (
    .clk      (soc_clk),
    .rst_n    (CU_reset_n),
    .set_en   (sb_set),
    .set_idx  (rd_reg),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .rd_idx_a (rs1_reg),
    .rd_idx_b (rs2_reg),
    .rd_a     (pend_rs1),
    .rd_b     (pend_rs2)
  );

  always_ff @(posedge soc_clk or negedge CU_reset_n) begin
    if (!CU_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    fetch_ready  = 1'b0;
    decode_start = 1'b0;
    ex_valid     = 1'b0;
    IDU_stall    = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    set_tmo      = 1'b0;
    set_inv      = 1'b0;
    issue_fire   = 1'b0;
    stall_inc    = 1'b0;
    case (state_reg)
      IDLE: begin
        // A flush in IDLE must not let a stale fetch slip in.
        fetch_ready = !flush;
        if (fetch_valid && !flush) begin
          accept     = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        decode_start = 1'b1;
        state_next   = flush ? IDLE : WAIT_IDU;
      end
      WAIT_IDU: begin
        if (flush) begin
          state_next = IDLE;
        end else if (IDU_ready && IDU_invalid) begin
          set_inv    = 1'b1;
          state_next = ERROR;
        end else if (IDU_ready) begin
          capture    = 1'b1;
          state_next = HAZARD;
        end else if (tmo_hit) begin
          set_tmo    = 1'b1;
          state_next = ERROR;
        end
      end
      HAZARD: begin
        IDU_stall = hazard;
        stall_inc = hazard;
        if (flush) begin
          state_next = IDLE;
        end else if (!hazard) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ex_valid = !flush;
        if (flush) begin
          state_next = IDLE;
        end else if (ex_ready) begin
          issue_fire = 1'b1;
          state_next = IDLE;
        end
      end
      ERROR: begin
        if (err_clear) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or negedge CU_reset_n) begin
    if (!CU_reset_n) begin
      instr_reg       <= '0;
      rd_reg          <= '0;
      rs1_reg         <= '0;
      rs2_reg         <= '0;
      is_load_reg     <= 1'b0;
      tmo_cnt_reg     <= '0;
      stall_cnt_reg   <= '0;
      timeout_err_reg <= 1'b0;
      invalid_err_reg <= 1'b0;
    end else begin
      if (accept) begin
        instr_reg <= fetch_instr;
      end
      if (state_reg == DECODE) begin
        tmo_cnt_reg <= '0;
      end else if (state_reg == WAIT_IDU) begin
        tmo_cnt_reg <= tmo_cnt_inc;
      end
      if (capture) begin
        rd_reg      <= IDU_rd;
        rs1_reg     <= IDU_rs1;
        rs2_reg     <= IDU_rs2;
        is_load_reg <= IDU_is_load;
      end
      if (stall_inc) begin
        stall_cnt_reg <= sat_inc(stall_cnt_reg);
      end
      if ((state_reg == ERROR) && err_clear) begin
        timeout_err_reg <= 1'b0;
        invalid_err_reg <= 1'b0;
      end else begin
        if (set_tmo) timeout_err_reg <= 1'b1;
        if (set_inv) invalid_err_reg <= 1'b1;
      end
    end
  end

  assign IDU_instr   = instr_reg;
  assign timeout_err = timeout_err_reg;
  assign invalid_err = invalid_err_reg;
  assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_cu_decode_seq.sv
// Directed table-driven bench for cu_decode_seq plus hand sequences for timeout, invalid and reset.
module tb_cu_decode_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_ready;
  logic        decode_start;
  logic [31:0] IDU_instr;
  logic        IDU_stall;
  logic        IDU_ready;
  logic        IDU_invalid;
  logic        IDU_is_load;
  logic [4:0]  IDU_rd;
  logic [4:0]  IDU_rs1;
  logic [4:0]  IDU_rs2;
  logic        ex_valid;
  logic        ex_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        err_clear;
  logic        timeout_err;
  logic        invalid_err;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cu_decode_seq #(.TIMEOUT_CYCLES(15)) dut (
    .soc_clk      (clk),
    .CU_reset_n   (rst_n),
    .fetch_valid  (fetch_valid),
    .fetch_instr  (fetch_instr),
    .fetch_ready  (fetch_ready),
    .decode_start (decode_start),
    .IDU_instr    (IDU_instr),
    .IDU_stall    (IDU_stall),
    .IDU_ready    (IDU_ready),
    .IDU_invalid  (IDU_invalid),
    .IDU_is_load  (IDU_is_load),
    .IDU_rd       (IDU_rd),
    .IDU_rs1      (IDU_rs1),
    .IDU_rs2      (IDU_rs2),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .err_clear    (err_clear),
    .timeout_err  (timeout_err),
    .invalid_err  (invalid_err),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    logic        fv;
    logic [31:0] fi;
    logic        ir;
    logic        ld;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exr;
    logic        wbv;
    logic [4:0]  wbr;
    logic        fl;
    logic [3:0]  e;   // {fetch_ready, decode_start, ex_valid, IDU_stall}
    logic [31:0] ei;
    logic [15:0] es;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] I0 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I1 = 32'h0000_2283;  // lw x5,0(x0)
  localparam logic [31:0] I2 = 32'h0002_8333;  // add x6,x5,x0
  localparam logic [31:0] I3 = 32'h0000_2383;  // lw x7,0(x0)
  localparam logic [31:0] I4 = 32'h0003_8433;  // add x8,x7,x0
  localparam logic [31:0] I5 = 32'h0000_2183;  // lw x3,0(x0)
  localparam logic [31:0] I6 = 32'h0030_04B3;  // add x9,x0,x3
  localparam logic [31:0] I7 = 32'h1234_5678;

  task automatic add(input logic fv, input logic [31:0] fi, input logic ir, input logic ld,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic exr, input logic wbv, input logic [4:0] wbr, input logic fl,
                     input logic [3:0] e, input logic [31:0] ei, input logic [15:0] es);
    vec_t v;
    v.fv = fv; v.fi = fi; v.ir = ir; v.ld = ld; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.exr = exr; v.wbv = wbv; v.wbr = wbr; v.fl = fl; v.e = e; v.ei = ei; v.es = es;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    fetch_valid = 0; fetch_instr = '0; IDU_ready = 0; IDU_invalid = 0; IDU_is_load = 0;
    IDU_rd = '0; IDU_rs1 = '0; IDU_rs2 = '0; ex_ready = 0; wb_valid = 0; wb_rd = '0;
    flush = 0; err_clear = 0;
  endtask

  // Accept one instruction and check the decode_start pulse; leaves the FSM entering WAIT_IDU.
  task automatic launch(input string tag, input logic [31:0] instr);
    @(negedge clk); clr_in(); fetch_valid = 1; fetch_instr = instr;
    #1 chk({tag, " accept fetch_ready"}, fetch_ready, 1);
    @(negedge clk); fetch_valid = 0;
    #1 chk({tag, " decode_start"}, decode_start, 1);
    chk({tag, " IDU_instr"}, IDU_instr, instr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset fetch_ready", fetch_ready, 1);
    chk("reset decode_start", decode_start, 0);
    chk("reset ex_valid", ex_valid, 0);
    chk("reset IDU_instr", IDU_instr, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset errs", {timeout_err, invalid_err}, 0);
    rst_n = 1;

    // Basic flow with an ex_ready stall-free issue.
    add(1,I0,0,0,0,0,0,1,0,0,0,4'b1000,0,0);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0100,I0,0);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0000,I0,0);
    add(0,0,1,0,1,0,0,1,0,0,0,4'b0000,I0,0);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0000,I0,0);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0010,I0,0);
    // Load x5, then a consumer of x5 that stalls until writeback.
    add(1,I1,0,0,0,0,0,1,0,0,0,4'b1000,I0,0);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0100,I1,0);
    add(0,0,1,1,5,0,0,1,0,0,0,4'b0000,I1,0);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0000,I1,0);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0010,I1,0);
    add(1,I2,0,0,0,0,0,1,0,0,0,4'b1000,I1,0);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0100,I2,0);
    add(0,0,1,0,6,5,0,1,0,0,0,4'b0000,I2,0);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0001,I2,0);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0001,I2,1);
    add(0,0,0,0,0,0,0,1,1,5,0,4'b0001,I2,2);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0000,I2,3);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0010,I2,3);
    // Load x7 flushed in ISSUE; the x7 consumer must not stall; ex_valid held for ex_ready.
    add(1,I3,0,0,0,0,0,1,0,0,0,4'b1000,I2,3);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0100,I3,3);
    add(0,0,1,1,7,0,0,1,0,0,0,4'b0000,I3,3);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0000,I3,3);
    add(0,0,0,0,0,0,0,1,0,0,1,4'b0000,I3,3);
    add(1,I4,0,0,0,0,0,1,0,0,0,4'b1000,I3,3);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0100,I4,3);
    add(0,0,1,0,8,7,0,1,0,0,0,4'b0000,I4,3);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0000,I4,3);
    add(0,0,0,0,0,0,0,0,0,0,0,4'b0010,I4,3);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0010,I4,3);
    // Load x3 issues in the same cycle as a writeback clear of x3: set wins.
    add(1,I5,0,0,0,0,0,1,0,0,0,4'b1000,I4,3);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0100,I5,3);
    add(0,0,1,1,3,0,0,1,0,0,0,4'b0000,I5,3);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0000,I5,3);
    add(0,0,0,0,0,0,0,1,1,3,0,4'b0010,I5,3);
    add(1,I6,0,0,0,0,0,1,0,0,0,4'b1000,I5,3);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0100,I6,3);
    add(0,0,1,0,9,0,3,1,0,0,0,4'b0000,I6,3);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0001,I6,3);
    add(0,0,0,0,0,0,0,1,1,3,0,4'b0001,I6,4);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0000,I6,5);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b0010,I6,5);
    // Flush in IDLE blocks acceptance.
    add(1,I7,0,0,0,0,0,1,0,0,1,4'b0000,I6,5);
    add(0,0,0,0,0,0,0,1,0,0,0,4'b1000,I6,5);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      fetch_valid = v.fv; fetch_instr = v.fi; IDU_ready = v.ir; IDU_invalid = 0;
      IDU_is_load = v.ld; IDU_rd = v.rd; IDU_rs1 = v.rs1; IDU_rs2 = v.rs2;
      ex_ready = v.exr; wb_valid = v.wbv; wb_rd = v.wbr; flush = v.fl; err_clear = 0;
      #1;
      chk($sformatf("v%0d fetch_ready", i), fetch_ready, v.e[3]);
      chk($sformatf("v%0d decode_start", i), decode_start, v.e[2]);
      chk($sformatf("v%0d ex_valid", i), ex_valid, v.e[1]);
      chk($sformatf("v%0d IDU_stall", i), IDU_stall, v.e[0]);
      chk($sformatf("v%0d IDU_instr", i), IDU_instr, v.ei);
      chk($sformatf("v%0d stall_cnt", i), stall_cnt, v.es);
      $display("vec %0d: fr=%0b ds=%0b ev=%0b st=%0b instr=%08h scnt=%0d",
               i, fetch_ready, decode_start, ex_valid, IDU_stall, IDU_instr, stall_cnt);
    end

    // Timeout: no IDU_ready for 15 WAIT_IDU cycles.
    launch("tmo", 32'hDEAD_0013);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      #1 chk($sformatf("tmo wait%0d timeout_err", k), timeout_err, 0);
    end
    @(negedge clk); fetch_valid = 1; fetch_instr = 32'h0000_0013;
    #1 chk("tmo timeout_err", timeout_err, 1);
    chk("tmo invalid_err", invalid_err, 0);
    chk("tmo fetch_ready", fetch_ready, 0);
    @(negedge clk); fetch_valid = 0; err_clear = 1;
    #1 chk("tmo held decode_start", decode_start, 0);
    chk("tmo held timeout_err", timeout_err, 1);
    @(negedge clk); err_clear = 0;
    #1 chk("tmo cleared fetch_ready", fetch_ready, 1);
    chk("tmo cleared timeout_err", timeout_err, 0);
    $display("seq timeout done");

    // IDU_ready+IDU_invalid on the very cycle the timeout would fire.
    launch("inv", 32'hFFFF_FFFF);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      #1 chk($sformatf("inv wait%0d invalid_err", k), invalid_err, 0);
    end
    @(negedge clk); IDU_ready = 1; IDU_invalid = 1;
    @(negedge clk); IDU_ready = 0; IDU_invalid = 0;
    #1 chk("inv invalid_err", invalid_err, 1);
    chk("inv timeout_err", timeout_err, 0);
    chk("inv fetch_ready", fetch_ready, 0);
    @(negedge clk); err_clear = 1;
    @(negedge clk); err_clear = 0;
    #1 chk("inv cleared fetch_ready", fetch_ready, 1);
    chk("inv cleared invalid_err", invalid_err, 0);
    $display("seq invalid done");

    // Asynchronous reset in WAIT_IDU, then a normal transaction.
    launch("rst", 32'hCAFE_0093);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst fetch_ready", fetch_ready, 1);
    chk("rst decode_start", decode_start, 0);
    chk("rst IDU_instr", IDU_instr, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst ex_valid", ex_valid, 0);
    #1 rst_n = 1;
    launch("post", 32'h0010_0113);
    @(negedge clk); IDU_ready = 1; IDU_rd = 2;
    @(negedge clk); IDU_ready = 0; IDU_rd = 0;
    #1 chk("post hazard ex_valid", ex_valid, 0);
    @(negedge clk); ex_ready = 1;
    #1 chk("post issue ex_valid", ex_valid, 1);
    @(negedge clk);
    #1 chk("post idle fetch_ready", fetch_ready, 1);
    $display("seq reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
